uart_crc_transmitter: RTL
=========================

UART_CRC_TRANSMITTER -- requirements
Module: uart_crc_transmitter

Interface
REQ-001 The block SHALL expose parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (115200 baud at 50 MHz).
REQ-002 The block SHALL expose parameter DEPTH, default 4, nibble FIFO entries (power of two, >=2).
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 nibble_in  input  4  payload nibble to send.
REQ-006 nibble_valid  input  1  nibble_in is valid this cycle.
REQ-007 nibble_ready  output  1  FIFO can accept a nibble this cycle.
REQ-008 TX  output  1  serial line; idle high.
REQ-009 busy  output  1  frame in progress (state != IDLE).
REQ-010 fifo_count  output  $clog2(DEPTH)+1  nibbles currently held in the FIFO.

Function
REQ-011 nibble_ready SHALL equal (fifo_count < DEPTH), with no look-ahead for a same-cycle pop.
REQ-012 A nibble SHALL be accepted on a rising edge where nibble_valid and nibble_ready are both 1; nibble_valid with nibble_ready=0 SHALL be ignored and not stalled.
REQ-013 The FIFO SHALL be first-in-first-out with wrap-around read and write pointers modulo DEPTH.
REQ-014 A push and a pop on the same edge SHALL leave fifo_count unchanged and preserve order.
REQ-015 The frame byte SHALL be {nibble[3:0], crc[3:0]}, where crc is the remainder of nibble·x^4 mod x^4+x+1 (poly 5'b10011), so the whole byte divides with zero remainder.
REQ-016 Reference CRC values SHALL be: nibble 0x0 -> byte 0x00, 0x1 -> 0x13, 0xF -> 0xF2.
REQ-017 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-018 IDLE: TX=1; if fifo_count>0, pop the head, latch the frame byte, drive TX=0, and go to START on the same edge.
REQ-019 START: hold TX=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-020 DATA: send byte bits LSB first (bit0 first), each for CLKS_PER_BIT cycles; after bit 7 go to STOP.
REQ-021 STOP: hold TX=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-022 One frame SHALL last exactly 10·CLKS_PER_BIT cycles, measured from the first TX=0 cycle to the end of the stop bit.
REQ-023 If a nibble is pending at the end of STOP, IDLE SHALL last exactly one cycle (TX=1) before the next start bit.
REQ-024 Latency: a nibble accepted into an empty FIFO in IDLE at edge N SHALL drive TX=0 from edge N+1.
REQ-025 A per-bit counter SHALL count 0..CLKS_PER_BIT-1 and clear on each bit transition.
REQ-026 TX SHALL come directly from a register (no combinational glitches).
REQ-027 Nibbles pushed during a frame SHALL NOT alter the latched byte being sent.

Reset
REQ-028 While reset=1 on a rising edge, the block SHALL set: state=IDLE, TX=1, busy=0, fifo_count=0, pointers=0, bit and baud counters=0, nibble_ready=1.
REQ-029 Reset during a frame SHALL abort it, drive TX=1 from the next edge, and discard all FIFO contents.

Verification
REQ-030 Push 0x1 in idle -> TX low from next edge, then start bit and bits 1,1,0,0,1,0,0,0, then stop bit; total 4340 cycles; busy=1 throughout.
REQ-031 Push 0x0, 0x1, 0xF back-to-back -> bytes 0x00, 0x13, 0xF2 in order, each separated by exactly one idle cycle; a model receiver sampling at bit centres sees zero CRC remainder for each.
REQ-032 Push 5 nibbles while a frame is active with DEPTH=4 -> nibble_ready=0 once fifo_count=4; the 5th nibble is dropped; the 4 held nibbles are sent intact.
REQ-033 At fifo_count=4, pop on the same edge as a valid push (ready=0) -> push refused, count=3; with count=2, simultaneous push+pop -> count stays 2.
REQ-034 Assert reset at bit 3 of the DATA state with 2 nibbles queued -> TX=1, busy=0, fifo_count=0 next edge; no further frames sent.
REQ-035 CLKS_PER_BIT=4 -> frame lasts 40 cycles; exhaustive all 16 nibbles match the CRC table.

Source files
------------

// File: rtl/uart_crc_transmitter.sv
// Serial transmitter: queues 4-bit payloads in a small FIFO and sends each as an
// 8N1 UART frame carrying {nibble, crc4} with generator x^4+x+1.
module uart_crc_transmitter #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DEPTH        = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [3:0]              nibble_in,
   input  logic                    nibble_valid,
   output logic                    nibble_ready,
   output logic                    TX,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_n;
   logic [3:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [CW-1:0] baud_cnt, baud_d;
   logic [2:0]    bit_idx, bit_idx_d;
   logic [7:0]    frame;
   logic [3:0]    head;
   logic          tx_q, tx_d;
   logic          push, pop, baud_done;

   // x^4 * n mod (x^4+x+1), expanded into parity equations
   function automatic logic [3:0] crc4(input logic [3:0] n);
      return {n[3] ^ n[2], n[2] ^ n[1], n[3] ^ n[1] ^ n[0], n[3] ^ n[0]};
   endfunction

   assign head         = mem[rd_ptr];
   assign nibble_ready = (count < (AW+1)'(DEPTH));
   assign push         = nibble_valid && nibble_ready;
   assign pop          = (state == IDLE) && (count != '0);
   assign baud_done    = (baud_cnt == CW'(CLKS_PER_BIT - 1));

   assign TX         = tx_q;
   assign busy       = (state != IDLE);
   assign fifo_count = count;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= nibble_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (!push && pop) begin
            count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:  if (count != '0)                   state_n = START;
         START: if (baud_done)                     state_n = DATA;
         DATA:  if (baud_done && bit_idx == 3'd7)  state_n = STOP;
         STOP:  if (baud_done)                     state_n = IDLE;
         default:                                  state_n = IDLE;
      endcase
   end

   // TX is computed from the next state so the line changes on the same edge as the state
   always_comb begin
      baud_d    = (state == IDLE || baud_done) ? '0 : baud_cnt + 1'b1;
      bit_idx_d = bit_idx;
      if (state == START) begin
         bit_idx_d = '0;
      end else if (state == DATA && baud_done) begin
         bit_idx_d = bit_idx + 1'b1;
      end
      case (state_n)
         START:   tx_d = 1'b0;
         DATA:    tx_d = frame[bit_idx_d];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_q     <= 1'b1;
         baud_cnt <= '0;
         bit_idx  <= '0;
         frame    <= '0;
      end else begin
         tx_q     <= tx_d;
         baud_cnt <= baud_d;
         bit_idx  <= bit_idx_d;
         if (pop) frame <= {head, crc4(head)};
      end
   end

endmodule
